// File: rtl/div_seq_16_pkg.sv
// Shared definitions for the sequential divider: default widths and FSM state encodings.
package div_seq_16_pkg;

  localparam int DIV_WIDTH = 16;
  localparam int DIV_CNT_W = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_dp_16.sv
// Restoring-divide datapath: {R,Q} shift register, divisor register, iteration counter.
// Latency: one quotient bit per step; step results are presented combinationally.
// Backpressure: none, the controller sequences load and step.
module div_dp_16
  import div_seq_16_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             cnt_last,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] div_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;
  logic             no_borrow;
  logic [WIDTH:0]   rem_sel;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic             unused_rem_msb;

  // The shifted partial remainder needs one extra bit before the trial subtract,
  // and the subtract itself one more for the borrow.
  assign rem_sh    = {rem_q, quo_q[WIDTH-1]};
  assign diff      = {1'b0, rem_sh} - {2'b00, div_q};
  assign no_borrow = ~diff[WIDTH+1];
  assign rem_sel   = no_borrow ? diff[WIDTH:0] : rem_sh;
  assign rem_nxt   = rem_sel[WIDTH-1:0];
  assign quo_nxt   = {quo_q[WIDTH-2:0], no_borrow};

  // After restore the remainder is below the divisor, so its top bit is always zero.
  assign unused_rem_msb = rem_sel[WIDTH];

  assign cnt_last  = (cnt_q == CNT_LAST);
  assign quotient  = quo_nxt;
  assign remainder = rem_nxt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      div_q <= divisor;
      cnt_q <= '0;
    end else if (step) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

endmodule

// File: rtl/div_seq_16.sv
// Sequential unsigned restoring divider: quotient/remainder, one quotient bit per clock.
// Latency: done pulses WIDTH cycles after the accepted start edge; divide-by-zero the cycle after.
// Backpressure: start is only accepted in IDLE or DONE; start during RUN is dropped.
module div_seq_16
  import div_seq_16_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_t       state;
  logic             accept;
  logic             dp_load;
  logic             dp_step;
  logic             cnt_last;
  logic [WIDTH-1:0] dp_quotient;
  logic [WIDTH-1:0] dp_remainder;

  assign accept  = start && ((state == S_IDLE) || (state == S_DONE));
  assign dp_load = accept && (divisor != '0);
  assign dp_step = (state == S_RUN);

  div_dp_16 #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_dp (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (dp_load),
    .step      (dp_step),
    .dividend  (dividend),
    .divisor   (divisor),
    .cnt_last  (cnt_last),
    .quotient  (dp_quotient),
    .remainder (dp_remainder)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            if (divisor == '0) begin
              // Zero divisor short-circuits straight to a result, no iterations.
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= S_DONE;
            end else begin
              div_by_zero <= 1'b0;
              busy        <= 1'b1;
              state       <= S_RUN;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (cnt_last) begin
            quotient  <= dp_quotient;
            remainder <= dp_remainder;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= S_DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_16.sv
// Scoreboard bench for div_seq_16: expected results queued at each accepted start, checked on done.
module tb_div_seq_16;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
    int           start_cyc;
  } exp_t;

  logic         clock;
  logic         reset_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  div_seq_16 dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Result monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clock) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("quotient", {16'd0, quotient}, {16'd0, e.q});
        check("remainder", {16'd0, remainder}, {16'd0, e.r});
        check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
        check("latency", cyc - e.start_cyc, e.lat);
        check("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == 0) begin
      e.q = 16'hFFFF; e.r = a; e.dbz = 1'b1; e.lat = 0;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0; e.lat = W;
    end
    e.start_cyc = cyc;
    exp_q.push_back(e);
  endtask

  // Drives start for one edge; the caller must be sure the DUT will accept it.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit expect_result);
    @(negedge clock);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clock);
    #1;
    start = 1'b0;
    if (expect_result) push_exp(a, b);
  endtask

  task automatic wait_empty(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      check({tag, "_timeout"}, 32'd1, 32'd0);
      exp_q.delete();
    end
    repeat (2) @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_q", {16'd0, quotient}, 32'd0);
    check("rst_r", {16'd0, remainder}, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // Basic divides and boundaries
    issue(16'd100, 16'd7, 1'b1);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    wait_empty("t1");
    issue(16'd65535, 16'd1, 1'b1);     wait_empty("t2a");
    issue(16'd5, 16'd9, 1'b1);         wait_empty("t2b");
    issue(16'd65535, 16'd65535, 1'b1); wait_empty("t2c");
    issue(16'd1234, 16'd0, 1'b1);      wait_empty("t3");
    check("dbz_held", {31'd0, div_by_zero}, 32'd1);

    // Start during RUN is ignored; previous results held while running
    issue(16'd100, 16'd7, 1'b1);
    repeat (4) @(negedge clock);
    start = 1'b1; dividend = 16'd50; divisor = 16'd3;
    @(negedge clock);
    start = 1'b0;
    check("busy_mid_run", {31'd0, busy}, 32'd1);
    check("q_stable_run", {16'd0, quotient}, 32'h0000_FFFF);
    check("r_stable_run", {16'd0, remainder}, 32'd1234);
    wait_empty("t4a");
    issue(16'd50, 16'd3, 1'b1);        wait_empty("t4b");

    // Reset in the middle of a run
    issue(16'd100, 16'd7, 1'b0);
    repeat (7) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_q", {16'd0, quotient}, 32'd0);
    check("abort_r", {16'd0, remainder}, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (20) @(negedge clock);
    issue(16'd40000, 16'd123, 1'b1);   wait_empty("t5");

    // Back-to-back: start held in the done cycle
    issue(16'd1000, 16'd33, 1'b1);
    begin
      int n = 0;
      while (!done && n < 40) begin
        @(negedge clock);
        n++;
      end
      check("b2b_done_seen", {31'd0, done}, 32'd1);
    end
    start = 1'b1; dividend = 16'd9; divisor = 16'd2;
    @(posedge clock);
    #1;
    start = 1'b0;
    push_exp(16'd9, 16'd2);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_empty("t6");

    // A few random operands, including occasional zero divisors
    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] a, b;
      a = W'($urandom);
      b = (i % 4 == 3) ? '0 : W'($urandom_range(1, 65535));
      issue(a, b, 1'b1);
      wait_empty("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
